dcm_pulse_tracker: RTL and testbench

Per-channel encoder/tacho front end for the DC motor controller. It conditions the raw motor_pulse[n] input and qualifies it with the channel's current drive direction (motor_left[n]/motor_right[n]). It produces the signed position count, a windowed speed measurement and a stall flag. The channel position/speed regulator consumes these outputs; one instance is built per motor channel.

---
 rtl/dcm_pulse_tracker.sv | 125 ++++++++++++
 tb/tb_dcm_pulse_tracker.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcm_pulse_tracker.sv
// Encoder/tacho front end: synchronises and de-glitches one motor pulse line, tracks signed position, windowed speed and stall.
// Latency: pulse_strobe 2+FILTER_CYCLES edges after the first edge that samples pulse_in high; position one edge after that.
// Backpressure: none; every output is a free-running level or strobe, valid every cycle.
module dcm_pulse_tracker #(
    parameter int POS_WIDTH     = 24,
    parameter int FILTER_CYCLES = 4,
    parameter int SPEED_WINDOW  = 65536,
    parameter int STALL_CYCLES  = 1000000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pulse_in,
    input  logic                 dir_left,
    input  logic                 dir_right,
    input  logic                 pos_load,
    input  logic [POS_WIDTH-1:0] pos_load_value,
    output logic [POS_WIDTH-1:0] position,
    output logic                 pulse_strobe,
    output logic [7:0]           speed,
    output logic                 speed_valid,
    output logic                 stall
);

    localparam int FCW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam int WW  = $clog2(SPEED_WINDOW);
    localparam int SCW = $clog2(STALL_CYCLES + 1);

    localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_CYCLES - 1);
    localparam logic [WW-1:0]  WIN_LAST  = WW'(SPEED_WINDOW - 1);
    localparam logic [SCW-1:0] STALL_MAX = SCW'(STALL_CYCLES);

    logic           sync1;
    logic           sync2;
    logic           filt;
    logic           filt_q;
    logic [FCW-1:0] filt_cnt;
    logic           last_left;
    logic [7:0]     pulse_cnt;
    logic [7:0]     pulse_cnt_next;
    logic [WW-1:0]  win_cnt;
    logic [SCW-1:0] stall_cnt;
    logic           driving;
    logic [POS_WIDTH-1:0] pos_step;

    assign driving = dir_left ^ dir_right;
    // All ones (-1) when the last commanded direction was left, +1 otherwise.
    assign pos_step = {{(POS_WIDTH-1){last_left}}, 1'b1};
    assign pulse_cnt_next = (pulse_strobe && (pulse_cnt != 8'hFF)) ? pulse_cnt + 8'd1 : pulse_cnt;
    assign stall = (stall_cnt == STALL_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1        <= 1'b0;
            sync2        <= 1'b0;
            filt         <= 1'b0;
            filt_q       <= 1'b0;
            filt_cnt     <= '0;
            pulse_strobe <= 1'b0;
        end else begin
            sync1        <= pulse_in;
            sync2        <= sync1;
            filt_q       <= filt;
            pulse_strobe <= filt & ~filt_q;
            // A new level is accepted only after FILTER_CYCLES consecutive disagreeing samples.
            if (sync2 != filt) begin
                if (filt_cnt == FILT_LAST) begin
                    filt     <= ~filt;
                    filt_cnt <= '0;
                end else begin
                    filt_cnt <= filt_cnt + FCW'(1);
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_left <= 1'b0;
            position  <= '0;
        end else begin
            if (driving) begin
                last_left <= dir_left;
            end
            // A load wins over a coincident strobe; the strobe still feeds speed and stall.
            if (pos_load) begin
                position <= pos_load_value;
            end else if (pulse_strobe) begin
                position <= position + pos_step;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win_cnt     <= '0;
            pulse_cnt   <= 8'd0;
            speed       <= 8'd0;
            speed_valid <= 1'b0;
        end else begin
            if (win_cnt == WIN_LAST) begin
                win_cnt     <= '0;
                speed       <= pulse_cnt_next;
                speed_valid <= 1'b1;
                pulse_cnt   <= 8'd0;
            end else begin
                win_cnt     <= win_cnt + WW'(1);
                speed_valid <= 1'b0;
                pulse_cnt   <= pulse_cnt_next;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (!driving || pulse_strobe) begin
            stall_cnt <= '0;
        end else if (stall_cnt != STALL_MAX) begin
            stall_cnt <= stall_cnt + SCW'(1);
        end
    end

endmodule

// File: tb/tb_dcm_pulse_tracker.sv
// Bench for dcm_pulse_tracker: vector table, hand-written corner sequences and random pulse trains
// checked every cycle against a pulse-level model (strobe schedule, position sum, per-window counts, idle-drive run length).
module tb_dcm_pulse_tracker;

    localparam int FC = 4;
    localparam int SW = 1000;
    localparam int ST = 500;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pulse_in = 1'b0;
    logic        dir_left = 1'b0;
    logic        dir_right = 1'b0;
    logic        pos_load = 1'b0;
    logic [23:0] pos_load_value = 24'd0;
    logic [23:0] position;
    logic        pulse_strobe;
    logic [7:0]  speed;
    logic        speed_valid;
    logic        stall;

    logic        pulse2 = 1'b0;
    logic [23:0] position2;
    logic        strobe2;
    logic [7:0]  speed2;
    logic        vld2;
    logic        stall2;

    always #5 clk = ~clk;

    dcm_pulse_tracker #(.POS_WIDTH(24), .FILTER_CYCLES(FC), .SPEED_WINDOW(SW), .STALL_CYCLES(ST)) dut (
        .clk(clk), .reset(reset), .pulse_in(pulse_in), .dir_left(dir_left), .dir_right(dir_right),
        .pos_load(pos_load), .pos_load_value(pos_load_value), .position(position),
        .pulse_strobe(pulse_strobe), .speed(speed), .speed_valid(speed_valid), .stall(stall)
    );

    dcm_pulse_tracker #(.POS_WIDTH(24), .FILTER_CYCLES(1), .SPEED_WINDOW(SW), .STALL_CYCLES(ST)) dut_f (
        .clk(clk), .reset(reset), .pulse_in(pulse2), .dir_left(1'b0), .dir_right(1'b0),
        .pos_load(1'b0), .pos_load_value(24'd0), .position(position2),
        .pulse_strobe(strobe2), .speed(speed2), .speed_valid(vld2), .stall(stall2)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int load_at = -1;
    logic [23:0] load_val = 24'd0;
    int n_strb = 0;
    int n_strb2 = 0;
    int n_vld = 0;
    int s, d, h, l;

    // Pulse-level reference model
    int          strobe_q[$];
    logic [23:0] m_pos = 24'd0;
    bit          m_left = 1'b0;
    bit          m_strobe = 1'b0;
    bit          m_vld = 1'b0;
    logic [7:0]  m_speed = 8'd0;
    int          m_run = 0;
    int          m_wcnt = 0;

    typedef struct {
        logic        l;
        logic        r;
        logic        ld_en;
        logic [23:0] ld;
        int          n;
        int          h;
        int          ns;
        logic [23:0] pos;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_position"}, 32'(position), 32'd0);
        chk({tag, "_strobe"}, 32'(pulse_strobe), 32'd0);
        chk({tag, "_speed"}, 32'(speed), 32'd0);
        chk({tag, "_speed_valid"}, 32'(speed_valid), 32'd0);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        chk({tag, "_f1_position"}, 32'(position2), 32'd0);
        chk({tag, "_f1_strobe"}, 32'(strobe2), 32'd0);
        chk({tag, "_f1_speed"}, 32'(speed2), 32'd0);
        chk({tag, "_f1_valid"}, 32'(vld2), 32'd0);
        chk({tag, "_f1_stall"}, 32'(stall2), 32'd0);
    endtask

    // One clock: apply the model's view of the coming edge, advance, then compare all outputs.
    task automatic step();
        pos_load = (cyc == load_at);
        pos_load_value = load_val;
        if (pos_load) m_pos = load_val;
        else if (m_strobe) m_pos = m_left ? m_pos - 24'd1 : m_pos + 24'd1;
        if (dir_left ^ dir_right) m_left = dir_left;
        if ((dir_left ^ dir_right) && !m_strobe) m_run = (m_run < ST) ? m_run + 1 : ST;
        else m_run = 0;
        @(posedge clk);
        #1;
        cyc++;
        pos_load = 1'b0;
        m_strobe = (strobe_q.size() > 0) && (strobe_q[0] == cyc);
        if (m_strobe) void'(strobe_q.pop_front());
        if (cyc % SW == 0) begin
            m_vld = 1'b1;
            m_speed = (m_wcnt > 255) ? 8'd255 : 8'(m_wcnt);
            m_wcnt = 0;
        end else begin
            m_vld = 1'b0;
        end
        if (m_strobe) m_wcnt++;
        if (pulse_strobe) n_strb++;
        if (strobe2) n_strb2++;
        if (speed_valid) n_vld++;
        chk("strobe", 32'(pulse_strobe), 32'(m_strobe));
        chk("position", 32'(position), 32'(m_pos));
        chk("speed_valid", 32'(speed_valid), 32'(m_vld));
        chk("speed", 32'(speed), 32'(m_speed));
        chk("stall", 32'(stall), 32'(m_run == ST));
    endtask

    // A pulse long enough to pass the filter must strobe 3+FC clocks after its rise is driven.
    task automatic pulse(input int hi, input int lo);
        if (hi >= FC) strobe_q.push_back(cyc + 3 + FC);
        pulse_in = 1'b1;
        repeat (hi) step();
        pulse_in = 1'b0;
        repeat (lo) step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        pulse_in = 1'b0;
        pulse2 = 1'b0;
        dir_left = 1'b0;
        dir_right = 1'b0;
        pos_load = 1'b0;
        load_at = -1;
        #1;
        chk_zero("reset");
        m_pos = 24'd0; m_left = 1'b0; m_strobe = 1'b0; m_vld = 1'b0;
        m_speed = 8'd0; m_run = 0; m_wcnt = 0;
        strobe_q.delete();
        cyc = 0; n_vld = 0; n_strb2 = 0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{1'b0, 1'b1, 1'b0, 24'h0,     5, 12, 5, 24'h000005};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 24'h0,     1,  3, 0, 24'h000005};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 24'h0,     1,  4, 1, 24'h000006};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 24'h2,     0,  0, 0, 24'h000002};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 24'h0,     4,  6, 4, 24'hFFFFFE};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 24'h0,     1,  6, 1, 24'hFFFFFD};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 24'h0,     1,  8, 1, 24'hFFFFFC};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 24'h0,     2,  9, 2, 24'hFFFFFE};

        do_reset();

        for (int i = 0; i < 8; i++) begin
            dir_left = tbl[i].l;
            dir_right = tbl[i].r;
            if (tbl[i].ld_en) begin
                load_at = cyc;
                load_val = tbl[i].ld;
            end
            step();
            s = n_strb;
            for (int k = 0; k < tbl[i].n; k++) pulse(tbl[i].h, (i == 0) ? 378 : 20);
            chk($sformatf("vec%0d_position", i), 32'(position), 32'(tbl[i].pos));
            chk($sformatf("vec%0d_strobes", i), n_strb - s, tbl[i].ns);
        end

        // Load coinciding with a strobe, then wrap past max positive
        load_val = 24'h7FFFFF;
        load_at = cyc + 3 + FC;
        pulse(6, 20);
        chk("load_vs_strobe", 32'(position), 32'h007FFFFF);
        pulse(6, 20);
        chk("wrap_max_pos", 32'(position), 32'h00800000);

        // Speed windows and asynchronous reset mid-window
        do_reset();
        repeat (7) pulse(5, 20);
        while (cyc < SW - 1) step();
        chk("speed_valid_early", 32'(speed_valid), 32'd0);
        step();
        chk("speed_valid_w1", 32'(speed_valid), 32'd1);
        chk("speed_w1", 32'(speed), 32'd7);
        chk("speed_valid_count_w1", n_vld, 1);
        while (cyc < 2 * SW) step();
        chk("speed_w2_empty", 32'(speed), 32'd0);
        repeat (3) pulse(5, 20);
        while (cyc < 3 * SW) step();
        chk("speed_w3", 32'(speed), 32'd3);
        repeat (2) pulse(5, 20);
        repeat (100) step();
        chk("pre_reset_position", 32'(position), 32'd12);
        #3;
        reset = 1'b0;
        #1;
        chk_zero("async_reset");

        // Stall assertion, clearing on a pulse, and staying clear when not driving
        do_reset();
        dir_right = 1'b1;
        while (cyc < ST - 1) step();
        chk("stall_before", 32'(stall), 32'd0);
        step();
        chk("stall_rise", 32'(stall), 32'd1);
        repeat (100) step();
        chk("stall_hold", 32'(stall), 32'd1);
        s = cyc + 3 + FC;
        strobe_q.push_back(s);
        pulse_in = 1'b1;
        for (int k = 0; cyc < s; k++) begin
            if (k == 6) pulse_in = 1'b0;
            step();
        end
        chk("stall_during_strobe", 32'(stall), 32'd1);
        chk("strobe_for_stall", 32'(pulse_strobe), 32'd1);
        step();
        chk("stall_clear", 32'(stall), 32'd0);
        repeat (20) step();
        dir_right = 1'b0;
        repeat (600) step();
        chk("stall_idle", 32'(stall), 32'd0);

        // FILTER_CYCLES=1 instance: a pulse every other cycle saturates speed
        do_reset();
        pulse2 = 1'b1;
        while (cyc < SW) begin
            step();
            pulse2 = ~pulse2;
            if (cyc == SW - 1) chk("f1_strobe_count", n_strb2, 498);
        end
        chk("f1_speed_valid", 32'(vld2), 32'd1);
        chk("f1_speed_sat", 32'(speed2), 32'd255);
        pulse2 = 1'b0;

        // Random pulse trains, directions and loads against the model
        do_reset();
        for (int seg = 0; seg < 40; seg++) begin
            d = int'($urandom_range(0, 3));
            dir_left = d[1];
            dir_right = d[0];
            if ($urandom_range(0, 4) == 0) begin
                load_at = cyc + int'($urandom_range(0, 15));
                load_val = 24'($urandom);
            end
            h = int'($urandom_range(1, 10));
            l = ($urandom_range(0, 7) == 0) ? int'($urandom_range(400, 700)) : int'($urandom_range(8, 40));
            pulse(h, l);
        end
        repeat (10) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
